// File: rtl/led_arbiter.sv
// Fixed-priority owner of the single user LED: grants one of three requesters per frame
// and renders its blink code (N pulses then a gap, or solid on when N is 0).
module led_arbiter #(
    parameter int unsigned TICK_DIV  = 16000,
    parameter int unsigned ON_TICKS  = 200,
    parameter int unsigned OFF_TICKS = 200,
    parameter int unsigned GAP_TICKS = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  REQ,
    input  logic [11:0] REQ_CNT,
    output logic [2:0]  GRANT,
    output logic        BUSY,
    output logic        LED
);

    localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_OO  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned DUR_MAX = (MAX_OO > GAP_TICKS) ? MAX_OO : GAP_TICKS;
    localparam int unsigned DUR_W   = $clog2(DUR_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] ON_LOAD  = DUR_W'(ON_TICKS - 1);
    localparam logic [DUR_W-1:0] OFF_LOAD = DUR_W'(OFF_TICKS - 1);
    localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP,
        S_SOLID
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [3:0]         pulse_q, pulse_d;
    logic [2:0]         grant_q, grant_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;

    logic               tick;
    logic               expired;
    logic               own_req;
    logic               higher_req;
    logic [2:0]         win;
    logic [3:0]         win_cnt;

    assign tick       = (pre_q == PRE_LAST);
    assign expired    = tick && (dur_q == '0);
    assign own_req    = |(REQ & grant_q);
    // Bits strictly above the current grantee; only used to preempt SOLID.
    assign higher_req = |(REQ & {grant_q[1] | grant_q[0], grant_q[0], 1'b0});

    // Fixed-priority pick and its pulse-count slice.
    always_comb begin
        win     = 3'b000;
        win_cnt = 4'd0;
        if (REQ[2]) begin
            win     = 3'b100;
            win_cnt = REQ_CNT[11:8];
        end else if (REQ[1]) begin
            win     = 3'b010;
            win_cnt = REQ_CNT[7:4];
        end else if (REQ[0]) begin
            win     = 3'b001;
            win_cnt = REQ_CNT[3:0];
        end
    end

    // Next-state, counters and registered outputs.
    always_comb begin
        state_d = state_q;
        pre_d   = tick ? '0 : pre_q + PRE_W'(1);
        dur_d   = (tick && dur_q != '0) ? dur_q - DUR_W'(1) : dur_q;
        pulse_d = pulse_q;
        grant_d = grant_q;

        if (state_q == S_IDLE) begin
            if (REQ != 3'b000) begin
                grant_d = win;
                pulse_d = win_cnt;
                dur_d   = ON_LOAD;
                state_d = (win_cnt == 4'd0) ? S_SOLID : S_ON;
            end
        end else if (!own_req) begin
            state_d = S_IDLE;
            grant_d = 3'b000;
        end else begin
            case (state_q)
                S_ON: begin
                    if (expired) begin
                        state_d = S_OFF;
                        dur_d   = OFF_LOAD;
                    end
                end
                S_OFF: begin
                    if (expired) begin
                        pulse_d = pulse_q - 4'd1;
                        if (pulse_q != 4'd1) begin
                            state_d = S_ON;
                            dur_d   = ON_LOAD;
                        end else begin
                            state_d = S_GAP;
                            dur_d   = GAP_LOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (expired) begin
                        state_d = S_IDLE;
                        grant_d = 3'b000;
                    end
                end
                S_SOLID: begin
                    if (tick && higher_req) begin
                        state_d = S_IDLE;
                        grant_d = 3'b000;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    grant_d = 3'b000;
                end
            endcase
        end

        // Restarting the prescaler makes each timed state exactly X*TICK_DIV cycles.
        if (state_d != state_q) begin
            pre_d = '0;
        end

        led_d  = (state_d == S_ON) || (state_d == S_SOLID);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            dur_q   <= '0;
            pulse_q <= 4'd0;
            grant_q <= 3'b000;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            dur_q   <= dur_d;
            pulse_q <= pulse_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign GRANT = grant_q;
    assign BUSY  = busy_q;
    assign LED   = led_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Bench for led_arbiter: directed vector table, hand-written corner sequences and
// random stimulus, all compared every cycle against a cycle-count reference model.
module tb_led_arbiter;

    localparam int TD  = 4;
    localparam int ONT = 2;
    localparam int OFT = 2;
    localparam int GPT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  REQ = 3'b000;
    logic [11:0] REQ_CNT = 12'h000;
    logic [2:0]  GRANT;
    logic        BUSY;
    logic        LED;

    int checks = 0;
    int errors = 0;

    led_arbiter #(
        .TICK_DIV (TD),
        .ON_TICKS (ONT),
        .OFF_TICKS(OFT),
        .GAP_TICKS(GPT)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .REQ_CNT(REQ_CNT),
        .GRANT  (GRANT),
        .BUSY   (BUSY),
        .LED    (LED)
    );

    always #5 CLK = ~CLK;

    // Reference model: segments measured in clock cycles since segment start.
    typedef enum {M_IDLE, M_HI, M_LO, M_GAP, M_SOLID} mph_t;
    mph_t m_ph   = M_IDLE;
    int   m_own  = 0;
    int   m_el   = 0;
    int   m_left = 0;

    function automatic int seg_len(input mph_t ph);
        case (ph)
            M_HI:    return ONT * TD;
            M_LO:    return OFT * TD;
            M_GAP:   return GPT * TD;
            default: return 1;
        endcase
    endfunction

    task automatic model_update(input logic rst, input logic [2:0] req, input logic [11:0] cnt);
        int n;
        if (rst) begin
            m_ph = M_IDLE;
            m_el = 0;
        end else if (m_ph == M_IDLE) begin
            if (req != 3'b000) begin
                m_own  = req[2] ? 2 : (req[1] ? 1 : 0);
                n      = (int'(cnt) >> (4 * m_own)) & 15;
                m_left = n;
                m_el   = 0;
                m_ph   = (n == 0) ? M_SOLID : M_HI;
            end
        end else if (!req[m_own]) begin
            m_ph = M_IDLE;
        end else if (m_ph == M_SOLID) begin
            if ((m_el % TD) == TD - 1 && (int'(req) >> (m_own + 1)) != 0) m_ph = M_IDLE;
            else m_el++;
        end else if (m_el == seg_len(m_ph) - 1) begin
            m_el = 0;
            case (m_ph)
                M_HI: m_ph = M_LO;
                M_LO: begin
                    m_left--;
                    m_ph = (m_left > 0) ? M_HI : M_GAP;
                end
                default: m_ph = M_IDLE;
            endcase
        end else begin
            m_el++;
        end
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock edge: advance model, then compare outputs away from the edge.
    task automatic step();
        logic [2:0] mg;
        logic       ml, mb;
        @(posedge CLK);
        model_update(RST, REQ, REQ_CNT);
        #1;
        mb = (m_ph != M_IDLE);
        mg = mb ? 3'(1 << m_own) : 3'b000;
        ml = (m_ph == M_HI) || (m_ph == M_SOLID);
        check("model", {3'b000, GRANT, LED, BUSY}, {3'b000, mg, ml, mb});
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [11:0] cnt;
        int          n;
        logic [2:0]  g;
        logic        led;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [2:0] req, input logic [11:0] cnt,
                       input int n, input logic [2:0] g, input logic led, input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.cnt = cnt; v.n = n;
        v.g = g; v.led = led; v.busy = busy;
        vecs.push_back(v);
    endtask

    initial begin
        int hi_cnt;
        int idle_at;

        // reset, first grant, abort, boundary preemption, solid preemption
        add(1, 3'b111, 12'h333,  3, 3'b000, 0, 0);
        add(0, 3'b111, 12'h333,  1, 3'b100, 1, 1);
        add(0, 3'b111, 12'h333,  7, 3'b100, 1, 1);
        add(0, 3'b111, 12'h333,  1, 3'b100, 0, 1);
        add(0, 3'b111, 12'h333,  8, 3'b100, 1, 1);
        add(0, 3'b011, 12'h333,  1, 3'b000, 0, 0);
        add(0, 3'b011, 12'h215,  1, 3'b010, 1, 1);
        add(0, 3'b111, 12'h215,  7, 3'b010, 1, 1);
        add(0, 3'b111, 12'h215,  1, 3'b010, 0, 1);
        add(0, 3'b111, 12'h215,  8, 3'b010, 0, 1);
        add(0, 3'b111, 12'h215, 15, 3'b010, 0, 1);
        add(0, 3'b111, 12'h215,  1, 3'b000, 0, 0);
        add(0, 3'b111, 12'h215,  1, 3'b100, 1, 1);
        add(0, 3'b001, 12'h000,  1, 3'b000, 0, 0);
        add(0, 3'b001, 12'h000,  1, 3'b001, 1, 1);
        add(0, 3'b001, 12'h000, 20, 3'b001, 1, 1);
        add(0, 3'b011, 12'h000,  3, 3'b001, 1, 1);
        add(0, 3'b011, 12'h000,  1, 3'b000, 0, 0);
        add(0, 3'b011, 12'h000,  1, 3'b010, 1, 1);
        add(0, 3'b011, 12'h000, 10, 3'b010, 1, 1);

        foreach (vecs[i]) begin
            RST = vecs[i].rst;
            REQ = vecs[i].req;
            REQ_CNT = vecs[i].cnt;
            for (int k = 0; k < vecs[i].n; k++) step();
            check($sformatf("vec%0d", i), {3'b000, GRANT, LED, BUSY},
                  {3'b000, vecs[i].g, vecs[i].led, vecs[i].busy});
        end

        // Reset during OFF of pulse 2, then a full fresh frame and its period.
        RST = 1'b1; step();
        RST = 1'b0; REQ = 3'b001; REQ_CNT = 12'h003;
        step();
        check("start", {3'b000, GRANT, LED, BUSY}, 8'b0000_0111);
        for (int k = 0; k < 27; k++) step();
        check("off2_led", {7'd0, LED}, 8'd0);
        RST = 1'b1; step();
        check("mid_rst", {3'b000, GRANT, LED, BUSY}, 8'b0000_0000);
        RST = 1'b0; step();
        check("restart", {3'b000, GRANT, LED, BUSY}, 8'b0000_0111);
        hi_cnt  = 1;
        idle_at = -1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (GRANT == 3'b000) begin
                idle_at = k;
                break;
            end
            if (LED) hi_cnt++;
        end
        check("idle_at", 8'(idle_at), 8'd64);
        check("hi_cycles", 8'(hi_cnt), 8'd24);
        step();
        check("regrant", {3'b000, GRANT, LED, BUSY}, 8'b0000_0111);

        // Randomized traffic, compared against the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(29, 0) == 0) REQ = 3'($urandom_range(7, 0));
            if ($urandom_range(49, 0) == 0)
                REQ_CNT = {4'($urandom_range(3, 0)), 4'($urandom_range(3, 0)), 4'($urandom_range(3, 0))};
            RST = ($urandom_range(399, 0) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
